// File: rtl/loop_stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// loop_stack_ctrl_pkg
// Shared definitions for the loop-stack controller and the instruction decoder
// that drives it: command opcodes, controller state codes and default sizes.
// No ports (package).
// -----------------------------------------------------------------------------
package loop_stack_ctrl_pkg;

   localparam int unsigned I_ADDR_WIDTH_DEF   = 16;
   localparam int unsigned MAX_LOOP_DEPTH_DEF = 256;

   // Decoder command encoding: '[' issues PUSH, ']' issues POP.
   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_PUSH  = 2'b01,
      OP_POP   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_e;

endpackage : loop_stack_ctrl_pkg

// File: rtl/loop_stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// loop_stack_ctrl_if
// Valid/ready command channel from the instruction decoder to the loop-stack
// controller.
//   cmd_valid  master->slave  request present
//   cmd_ready  slave->master  request accepted when valid & ready
//   cmd_op     master->slave  NOP / PUSH / POP / CLEAR
//   cmd_data   master->slave  loop-start address to push (PUSH only)
// -----------------------------------------------------------------------------
interface loop_stack_ctrl_if #(
   parameter int unsigned I_ADDR_WIDTH = 16
);
   import loop_stack_ctrl_pkg::*;

   logic                    cmd_valid;
   logic                    cmd_ready;
   op_e                     cmd_op;
   logic [I_ADDR_WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);

endinterface : loop_stack_ctrl_if

// File: rtl/loop_stack_ctrl.sv
// -----------------------------------------------------------------------------
// loop_stack_ctrl
// Owns the loop-stack pointer, converts decoder PUSH/POP/CLEAR commands into
// traffic for a synchronous-read stack RAM, and keeps a cached top-of-stack so
// fetch sees the loop-start address without a RAM read delay.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   cmd                command channel (slave side)
//   o_top_valid        o_top_data holds the current top entry
//   o_top_data         cached top-of-stack
//   o_depth            entries currently stored
//   o_empty / o_full   depth==0 / depth==MAX_LOOP_DEPTH
//   o_err_overflow     sticky: PUSH seen while full
//   o_err_underflow    sticky: POP seen while empty
//   o_ram_write_*      RAM write port (combinational in the accept cycle)
//   o_ram_read_addr    RAM read address
//   i_ram_read_data    RAM read data, valid one cycle after o_ram_read_addr
// -----------------------------------------------------------------------------
module loop_stack_ctrl
   import loop_stack_ctrl_pkg::*;
#(
   parameter int unsigned I_ADDR_WIDTH   = I_ADDR_WIDTH_DEF,
   parameter int unsigned MAX_LOOP_DEPTH = MAX_LOOP_DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   loop_stack_ctrl_if.slave        cmd,
   output logic                    o_top_valid,
   output logic [I_ADDR_WIDTH-1:0] o_top_data,
   output logic [31:0]             o_depth,
   output logic                    o_empty,
   output logic                    o_full,
   output logic                    o_err_overflow,
   output logic                    o_err_underflow,
   output logic [31:0]             o_ram_write_addr,
   output logic                    o_ram_write_en,
   output logic [I_ADDR_WIDTH-1:0] o_ram_write_data,
   output logic [31:0]             o_ram_read_addr,
   input  logic [I_ADDR_WIDTH-1:0] i_ram_read_data
);

   state_e                  r_state,     w_state_nxt;
   logic [31:0]             r_depth,     w_depth_nxt;
   logic                    r_top_valid, w_top_valid_nxt;
   logic [I_ADDR_WIDTH-1:0] r_top_data,  w_top_data_nxt;
   logic                    r_err_ovf,   w_err_ovf_nxt;
   logic                    r_err_unf,   w_err_unf_nxt;

   logic w_empty;
   logic w_full;
   logic w_accept;

   assign w_empty  = (r_depth == 32'd0);
   assign w_full   = (r_depth == 32'(MAX_LOOP_DEPTH));
   assign w_accept = cmd.cmd_valid && (r_state == ST_IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statements can leave a value held and infer a latch.
      w_state_nxt      = r_state;
      w_depth_nxt      = r_depth;
      w_top_valid_nxt  = r_top_valid;
      w_top_data_nxt   = r_top_data;
      w_err_ovf_nxt    = r_err_ovf;
      w_err_unf_nxt    = r_err_unf;
      cmd.cmd_ready    = (r_state == ST_IDLE);
      o_ram_write_en   = 1'b0;
      o_ram_write_addr = r_depth;
      o_ram_write_data = cmd.cmd_data;
      // Idle read address tracks the current top; only meaningful during a POP.
      o_ram_read_addr  = w_empty ? 32'd0 : r_depth - 32'd1;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd.cmd_op)
                  OP_PUSH: begin
                     if (w_full) begin
                        w_err_ovf_nxt = 1'b1;
                     end else begin
                        // New entry goes to RAM and straight into the top cache.
                        o_ram_write_en  = 1'b1;
                        w_depth_nxt     = r_depth + 32'd1;
                        w_top_data_nxt  = cmd.cmd_data;
                        w_top_valid_nxt = 1'b1;
                     end
                  end
                  OP_POP: begin
                     if (w_empty) begin
                        w_err_unf_nxt = 1'b1;
                     end else if (r_depth == 32'd1) begin
                        w_depth_nxt     = 32'd0;
                        w_top_valid_nxt = 1'b0;
                     end else begin
                        // Fetch the entry that becomes the new top; it lands next cycle.
                        o_ram_read_addr = r_depth - 32'd2;
                        w_depth_nxt     = r_depth - 32'd1;
                        w_top_valid_nxt = 1'b0;
                        w_state_nxt     = ST_REFILL;
                     end
                  end
                  OP_CLEAR: begin
                     w_depth_nxt     = 32'd0;
                     w_top_valid_nxt = 1'b0;
                     w_err_ovf_nxt   = 1'b0;
                     w_err_unf_nxt   = 1'b0;
                  end
                  default: ;  // OP_NOP
               endcase
            end
         end
         ST_REFILL: begin
            w_top_data_nxt  = i_ram_read_data;
            w_top_valid_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_depth     <= 32'd0;
         r_top_valid <= 1'b0;
         r_top_data  <= '0;
         r_err_ovf   <= 1'b0;
         r_err_unf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_depth     <= w_depth_nxt;
         r_top_valid <= w_top_valid_nxt;
         r_top_data  <= w_top_data_nxt;
         r_err_ovf   <= w_err_ovf_nxt;
         r_err_unf   <= w_err_unf_nxt;
      end
   end

   assign o_top_valid     = r_top_valid;
   assign o_top_data      = r_top_data;
   assign o_depth         = r_depth;
   assign o_empty         = w_empty;
   assign o_full          = w_full;
   assign o_err_overflow  = r_err_ovf;
   assign o_err_underflow = r_err_unf;

endmodule : loop_stack_ctrl

// File: tb/tb_loop_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_loop_stack_ctrl
// Pairs loop_stack_ctrl (MAX_LOOP_DEPTH=4) with a synchronous-read stack RAM
// model and checks it against a queue-based stack model every cycle, after a
// directed sequence with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_loop_stack_ctrl;
   import loop_stack_ctrl_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   loop_stack_ctrl_if #(.I_ADDR_WIDTH(AW)) u_if ();

   logic          top_valid;
   logic [AW-1:0] top_data;
   logic [31:0]   depth;
   logic          empty, full, err_ovf, err_unf;
   logic [31:0]   ram_waddr, ram_raddr;
   logic          ram_we;
   logic [AW-1:0] ram_wdata, ram_rdata;

   loop_stack_ctrl #(.I_ADDR_WIDTH(AW), .MAX_LOOP_DEPTH(MAX)) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd              (u_if),
      .o_top_valid      (top_valid),
      .o_top_data       (top_data),
      .o_depth          (depth),
      .o_empty          (empty),
      .o_full           (full),
      .o_err_overflow   (err_ovf),
      .o_err_underflow  (err_unf),
      .o_ram_write_addr (ram_waddr),
      .o_ram_write_en   (ram_we),
      .o_ram_write_data (ram_wdata),
      .o_ram_read_addr  (ram_raddr),
      .i_ram_read_data  (ram_rdata)
   );

   // Stack RAM: synchronous write, one-cycle registered read.
   logic [AW-1:0] ram_mem [0:MAX-1];
   always @(posedge clk) begin
      if (ram_we && ram_waddr < MAX) ram_mem[ram_waddr[1:0]] <= ram_wdata;
      ram_rdata <= ram_mem[ram_raddr[1:0]];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the stack as a queue plus flags.
   logic [AW-1:0] m_stk [$];
   bit            m_busy, m_topv, m_ovf, m_unf, m_known;
   logic [AW-1:0] m_topd;
   logic          last_we;
   logic [31:0]   last_waddr;

   // Compares all DUT outputs against the model for the inputs currently applied.
   task automatic compare();
      int          sz;
      bit          acc, exp_we;
      logic [31:0] exp_raddr;
      sz  = m_stk.size();
      acc = u_if.cmd_valid && !m_busy;
      check("cmd_ready", 32'(u_if.cmd_ready), 32'(!m_busy));
      check("depth",     depth,               32'(sz));
      check("empty",     32'(empty),          32'(sz == 0));
      check("full",      32'(full),           32'(sz == MAX));
      check("top_valid", 32'(top_valid),      32'(m_topv));
      check("top_data",  32'(top_data),       32'(m_topd));
      check("err_ovf",   32'(err_ovf),        32'(m_ovf));
      check("err_unf",   32'(err_unf),        32'(m_unf));
      exp_we = acc && (u_if.cmd_op == OP_PUSH) && (sz < MAX);
      check("ram_we",    32'(ram_we),         32'(exp_we));
      if (exp_we) begin
         check("ram_waddr", ram_waddr,        32'(sz));
         check("ram_wdata", 32'(ram_wdata),   32'(u_if.cmd_data));
      end
      if (acc && u_if.cmd_op == OP_POP && sz >= 2) exp_raddr = 32'(sz - 2);
      else if (sz > 0)                             exp_raddr = 32'(sz - 1);
      else                                         exp_raddr = 32'd0;
      check("ram_raddr", ram_raddr, exp_raddr);
   endtask

   task automatic model_update(input logic r, input logic v, input op_e op, input logic [AW-1:0] d);
      if (r) begin
         m_stk.delete();
         m_busy = 0; m_topv = 0; m_topd = '0; m_ovf = 0; m_unf = 0; m_known = 1;
      end else if (m_busy) begin
         m_busy = 0; m_topv = 1; m_topd = m_stk[$];
      end else if (v) begin
         case (op)
            OP_PUSH: begin
               if (m_stk.size() == MAX) m_ovf = 1;
               else begin m_stk.push_back(d); m_topv = 1; m_topd = d; end
            end
            OP_POP: begin
               if (m_stk.size() == 0) m_unf = 1;
               else begin
                  void'(m_stk.pop_back());
                  m_topv = 0;
                  m_busy = (m_stk.size() > 0);
               end
            end
            OP_CLEAR: begin m_stk.delete(); m_topv = 0; m_ovf = 0; m_unf = 0; end
            default: ;
         endcase
      end
   endtask

   // One clock: drive at negedge, compare, advance model, return just after posedge.
   task automatic step(input logic r, input logic v, input op_e op, input logic [AW-1:0] d);
      @(negedge clk);
      rst = r; u_if.cmd_valid = v; u_if.cmd_op = op; u_if.cmd_data = d;
      #1;
      last_we    = ram_we;
      last_waddr = ram_waddr;
      if (m_known) compare();
      model_update(r, v, op, d);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] d); step(1'b0, 1'b1, OP_PUSH,  d);     endtask
   task automatic pop();                        step(1'b0, 1'b1, OP_POP,   '0);    endtask
   task automatic clr();                        step(1'b0, 1'b1, OP_CLEAR, '0);    endtask
   task automatic nop();                        step(1'b0, 1'b0, OP_NOP,   '0);    endtask

   initial begin
      int  r;
      op_e op;
      u_if.cmd_valid = 1'b0; u_if.cmd_op = OP_NOP; u_if.cmd_data = '0;

      // Reset state.
      step(1'b1, 1'b0, OP_NOP, '0);
      step(1'b1, 1'b0, OP_NOP, '0);
      check("rst depth",     depth,                  32'd0);
      check("rst ready",     32'(u_if.cmd_ready),    32'd1);
      check("rst top_valid", 32'(top_valid),         32'd0);
      check("rst top_data",  32'(top_data),          32'd0);
      check("rst ram_we",    32'(ram_we),            32'd0);

      // Three pushes, top updated one cycle after each.
      push(16'h0010); check("push1 top", 32'(top_data), 32'h0010);
      push(16'h0020); check("push2 top", 32'(top_data), 32'h0020);
      push(16'h0030); check("push3 top", 32'(top_data), 32'h0030);
      check("push3 depth", depth, 32'd3);

      // POP from depth 3: one busy cycle, then refilled top.
      pop();
      check("pop ready",     32'(u_if.cmd_ready), 32'd0);
      check("pop top_valid", 32'(top_valid),      32'd0);
      nop();
      check("refill top",    32'(top_data),       32'h0020);
      check("refill valid",  32'(top_valid),      32'd1);
      check("refill depth",  depth,               32'd2);

      // Fill to 4 then overflow.
      clr();
      for (int i = 1; i <= 4; i++) push(16'h0100 + 16'(i));
      check("fill full", 32'(full), 32'd1);
      push(16'h0099);
      check("ovf write",  32'(last_we),  32'd0);
      check("ovf flag",   32'(err_ovf),  32'd1);
      check("ovf top",    32'(top_data), 32'h0104);
      check("ovf depth",  depth,         32'd4);

      // Underflow then CLEAR.
      clr();
      pop();
      check("unf flag",  32'(err_unf), 32'd1);
      check("unf depth", depth,        32'd0);
      push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004); push(16'h0005);
      check("both flags", {30'd0, err_ovf, err_unf}, 32'd3);
      clr();
      check("clr flags", {30'd0, err_ovf, err_unf}, 32'd0);

      // PUSH held through REFILL.
      push(16'h000A); push(16'h000B);
      pop();
      push(16'h0055);
      check("held blocked we", 32'(last_we), 32'd0);
      push(16'h0055);
      check("held we",    32'(last_we),    32'd1);
      check("held waddr", last_waddr,      32'd1);
      check("held top",   32'(top_data),   32'h0055);
      check("held depth", depth,           32'd2);

      // Reset during REFILL.
      pop();
      step(1'b1, 1'b0, OP_NOP, '0);
      check("rst refill depth", depth,               32'd0);
      check("rst refill valid", 32'(top_valid),      32'd0);
      check("rst refill ready", 32'(u_if.cmd_ready), 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if      (r < 40) op = OP_PUSH;
         else if (r < 75) op = OP_POP;
         else if (r < 80) op = OP_CLEAR;
         else             op = OP_NOP;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), op, AW'($urandom));
      end
      nop();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_loop_stack_ctrl
